wb_obi_bridge: RTL and testbench
================================

# wb_obi_bridge

Single-clock Wishbone B4 classic responder that converts each Wishbone cycle into one OBI initiator transaction. It is the reverse-direction counterpart of the SoC's OBI-to-WB bridge: it lets an external Wishbone master (debug host, DMA, test controller) drive OBI responders inside the SoC, such as the instruction/data RAM ports or the peripheral mux. Exactly one transaction is in flight at a time, and all outputs are registered.

## Interface
- ADDR_WIDTH, 32, width of the WB and OBI address.
- DATA_WIDTH, 32, data width; must be 32 (byte enables are 4 bits).
- TIMEOUT_CYCLES, 256, cycles allowed from OBI req to rvalid; used only when WB_OBI_BRIDGE_TIMEOUT_EN is defined.
- clk_i  in  1  clock for both sides.
- rst_ni  in  1  reset; asynchronous, active-low.
- wb_adr_i  in  ADDR_WIDTH  byte address.
- wb_dat_i  in  32  write data.
- wb_dat_o  out  32  read data; valid while wb_ack_o=1.
- wb_we_i  in  1  1=write.
- wb_sel_i  in  4  byte select.
- wb_stb_i  in  1  strobe.
- wb_cyc_i  in  1  cycle valid.
- wb_ack_o  out  1  one-cycle acknowledge.
- wb_err_o  out  1  one-cycle error (timeout).
- obi_req_o  out  1  OBI request.
- obi_gnt_i  in  1  OBI grant.
- obi_addr_o  out  ADDR_WIDTH  OBI address.
- obi_we_o  out  1  OBI write enable.
- obi_be_o  out  4  OBI byte enable.
- obi_wdata_o  out  32  OBI write data.
- obi_rvalid_i  in  1  OBI response valid.
- obi_rdata_i  in  32  OBI read data.

## Operation
- FSM states:
  - IDLE: waiting for a WB cycle.
  - REQ: OBI req asserted, waiting for gnt.
  - RESP: waiting for rvalid.
  - ACK: wb_ack_o=1 for one cycle.
  - ERR: wb_err_o=1 for one cycle.
- IDLE→REQ when wb_cyc_i&wb_stb_i is sampled. On that edge, wb_adr_i/wb_dat_i/wb_we_i/wb_sel_i are latched into obi_addr_o/obi_wdata_o/obi_we_o/obi_be_o.
- REQ: obi_req_o=1 and the OBI outputs are held stable. Sampling gnt=1 moves to RESP and drops req on the same edge.
- RESP: sampling rvalid=1 moves to ACK. For reads (latched we=0), obi_rdata_i is captured into wb_dat_o on that edge. For writes, wb_dat_o is not updated.
- ACK→IDLE unconditionally. The WB master must drop stb or present a new cycle; a new cycle is not sampled in ACK.
- Abort: if wb_cyc_i=0 is sampled in REQ or RESP, the OBI transaction still completes (req is never withdrawn before gnt). The bridge then goes to IDLE instead of ACK, and no ack is issued.
- obi_rvalid_i arriving in IDLE or REQ is ignored.
- Reset values: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, obi_req_o=0, obi_addr_o=0, obi_we_o=0, obi_be_o=0, obi_wdata_o=0; state IDLE; timeout counter 0.
- Reset mid-transaction returns to IDLE immediately, with req dropped.

## Timing
- Edge E0 samples stb → obi_req_o=1 after E0.
- With gnt=1 at E1 and rvalid=1 at E2, wb_ack_o is high between E2 and E3.
- Minimum latency is 3 cycles from the stb-sample edge to ack; throughput is one transaction per 4 cycles.
- Each additional gnt or rvalid wait cycle adds one cycle.
- wb_ack_o and wb_err_o are never both 1 and are never high for more than one cycle.

## Configuration
- WB_OBI_BRIDGE_TIMEOUT_EN defined:
  - A counter is cleared on IDLE→REQ and increments every cycle in REQ/RESP.
  - When the counter equals TIMEOUT_CYCLES-1 and neither the exit condition (gnt in REQ, rvalid in RESP) nor an abort applies, the FSM goes to ERR: req dropped, wb_dat_o unchanged, then IDLE.
  - Counter width is $clog2(TIMEOUT_CYCLES)+1 and saturates.
- Not defined: no counter, ERR state unreachable, wb_err_o tied 0, and the bridge waits indefinitely.

## Structure
- The state enum (e_wb_obi_state) and the byte-enable width constant go in the shared SoC bus package, alongside the chip/block select enums planned for it.
- One sub-module, wb_obi_timeout (the counter plus expiry compare), is instantiated only under WB_OBI_BRIDGE_TIMEOUT_EN.

## Test plan
- Read: adr=0x00400010, responder gives gnt the same cycle and rvalid next with rdata=0xDEADBEEF → obi_addr_o=0x00400010, obi_we_o=0; wb_dat_o=0xDEADBEEF with ack exactly 3 cycles after stb is sampled.
- Write with wait states: dat=0x12345678, sel=4'b0011, gnt delayed 2 cycles → req held for 3 cycles with stable addr/wdata/be=4'b0011; ack 5 cycles after stb; wb_dat_o unchanged.
- Back-to-back: two reads with stb re-asserted immediately after ack → second req starts exactly 1 cycle after the first ack; no stray acks.
- Abort: cyc dropped while in RESP → OBI completes, no ack or err; a following read acks normally.
- Timeout (macro on, TIMEOUT_CYCLES=8): gnt never asserted → wb_err_o pulses once 8 cycles after req rose, req drops, FSM returns to IDLE.
- Reset asserted while in REQ → all outputs return to 0 asynchronously; after release, a read completes with correct data.

Source files
------------

// File: rtl/wb_obi_bridge_pkg.sv
// Shared SoC bus definitions: bridge state encoding and byte-enable width.
package wb_obi_bridge_pkg;

    localparam int unsigned BE_WIDTH = 4;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_RESP = 3'd2,
        ST_ACK  = 3'd3,
        ST_ERR  = 3'd4
    } e_wb_obi_state;

endpackage

// File: rtl/wb_obi_timeout.sv
// Saturating request-to-response watchdog; expired is high on the last allowed cycle.
module wb_obi_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count <= '0;
        end else if (start) begin
            count <= '0;
        end else if (run && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = run && (count == LAST);

endmodule

// File: rtl/wb_obi_bridge.sv
// Wishbone B4 classic responder driving one OBI transaction per WB cycle.
// Define WB_OBI_BRIDGE_TIMEOUT_EN to add the req-to-rvalid timeout and ERR response.
module wb_obi_bridge
    import wb_obi_bridge_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [ADDR_WIDTH-1:0] wb_adr_i,
    input  logic [DATA_WIDTH-1:0] wb_dat_i,
    output logic [DATA_WIDTH-1:0] wb_dat_o,
    input  logic                  wb_we_i,
    input  logic [BE_WIDTH-1:0]   wb_sel_i,
    input  logic                  wb_stb_i,
    input  logic                  wb_cyc_i,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  obi_req_o,
    input  logic                  obi_gnt_i,
    output logic [ADDR_WIDTH-1:0] obi_addr_o,
    output logic                  obi_we_o,
    output logic [BE_WIDTH-1:0]   obi_be_o,
    output logic [DATA_WIDTH-1:0] obi_wdata_o,
    input  logic                  obi_rvalid_i,
    input  logic [DATA_WIDTH-1:0] obi_rdata_i,
    output logic [2:0]            state_o
);

    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("wb_obi_bridge: DATA_WIDTH must be 32");
    end
    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("wb_obi_bridge: TIMEOUT_CYCLES must be at least 2");
    end

    e_wb_obi_state state;
    logic          aborted;
    logic          timeout;
    logic          start;

    assign start   = (state == ST_IDLE) && wb_cyc_i && wb_stb_i;
    assign state_o = state;

`ifdef WB_OBI_BRIDGE_TIMEOUT_EN
    wb_obi_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .start  (start),
        .run    ((state == ST_REQ) || (state == ST_RESP)),
        .expired(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    // An aborted cycle still runs the OBI side to completion; only the WB response is suppressed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= ST_IDLE;
            aborted     <= 1'b0;
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
            wb_dat_o    <= '0;
            obi_req_o   <= 1'b0;
            obi_addr_o  <= '0;
            obi_we_o    <= 1'b0;
            obi_be_o    <= '0;
            obi_wdata_o <= '0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_REQ;
                        aborted     <= 1'b0;
                        obi_req_o   <= 1'b1;
                        obi_addr_o  <= wb_adr_i;
                        obi_wdata_o <= wb_dat_i;
                        obi_we_o    <= wb_we_i;
                        obi_be_o    <= wb_sel_i;
                    end
                end
                ST_REQ: begin
                    if (!wb_cyc_i) aborted <= 1'b1;
                    if (obi_gnt_i) begin
                        state     <= ST_RESP;
                        obi_req_o <= 1'b0;
                    end else if (timeout && wb_cyc_i && !aborted) begin
                        state     <= ST_ERR;
                        obi_req_o <= 1'b0;
                        wb_err_o  <= 1'b1;
                    end
                end
                ST_RESP: begin
                    if (!wb_cyc_i) aborted <= 1'b1;
                    if (obi_rvalid_i) begin
                        if (aborted || !wb_cyc_i) begin
                            state <= ST_IDLE;
                        end else begin
                            state    <= ST_ACK;
                            wb_ack_o <= 1'b1;
                            if (!obi_we_o) wb_dat_o <= obi_rdata_i;
                        end
                    end else if (timeout && wb_cyc_i && !aborted) begin
                        state    <= ST_ERR;
                        wb_err_o <= 1'b1;
                    end
                end
                ST_ACK:  state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_obi_bridge.sv
// Scoreboard bench for wb_obi_bridge: random WB traffic against an OBI responder model.
module tb_wb_obi_bridge;
    import wb_obi_bridge_pkg::*;

    localparam int TO = 8;

    logic        clk;
    logic        rst_n;
    logic [31:0] wb_adr, wb_dat_w, wb_dat_r;
    logic        wb_we, wb_stb, wb_cyc, wb_ack, wb_err;
    logic [3:0]  wb_sel;
    logic        obi_req, obi_gnt, obi_we, obi_rvalid;
    logic [31:0] obi_addr, obi_wdata, obi_rdata;
    logic [3:0]  obi_be;
    logic [2:0]  state_dbg;

    wb_obi_bridge #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .wb_adr_i(wb_adr), .wb_dat_i(wb_dat_w), .wb_dat_o(wb_dat_r),
        .wb_we_i(wb_we), .wb_sel_i(wb_sel), .wb_stb_i(wb_stb), .wb_cyc_i(wb_cyc),
        .wb_ack_o(wb_ack), .wb_err_o(wb_err),
        .obi_req_o(obi_req), .obi_gnt_i(obi_gnt), .obi_addr_o(obi_addr),
        .obi_we_o(obi_we), .obi_be_o(obi_be), .obi_wdata_o(obi_wdata),
        .obi_rvalid_i(obi_rvalid), .obi_rdata_i(obi_rdata), .state_o(state_dbg)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference data ----------------
    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                          input logic [3:0] sel);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) m[b*8 +: 8] = {8{sel[b]}};
        return (old & ~m) | (d & m);
    endfunction

    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] obi_mem [logic [31:0]];
    logic [31:0] last_rd;

    // ---------------- OBI responder model ----------------
    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        int          req_cycles;
        logic        stable;
    } obi_t;

    obi_t        obi_q[$];
    int          gnt_delay = 0, rv_delay = 0;
    int          rvalid_pulses = 0;

    initial begin
        obi_t        cur;
        bit          pending = 0, seen = 0;
        int          wait_cnt = 0, rv_cnt = 0, rv_lim = 0;
        logic [31:0] resp_data = 0;
        obi_gnt = 0; obi_rvalid = 0; obi_rdata = 0;
        forever begin
            @(negedge clk);
            obi_gnt    = 1'b0;
            obi_rvalid = 1'b0;
            obi_rdata  = $urandom;
            if (!rst_n) begin
                pending = 0; seen = 0; wait_cnt = 0;
            end else if (pending) begin
                if (rv_cnt >= rv_lim) begin
                    obi_rvalid = 1'b1;
                    obi_rdata  = resp_data;
                    pending    = 0;
                    rvalid_pulses++;
                end else rv_cnt++;
            end else if (obi_req) begin
                obi_rvalid = ($urandom_range(0, 3) == 0);  // must be ignored in REQ
                if (!seen) begin
                    seen = 1;
                    cur.addr = obi_addr; cur.we = obi_we; cur.be = obi_be;
                    cur.wdata = obi_wdata; cur.req_cycles = 0; cur.stable = 1'b1;
                end else if (cur.addr !== obi_addr || cur.we !== obi_we ||
                             cur.be !== obi_be || cur.wdata !== obi_wdata) begin
                    cur.stable = 1'b0;
                end
                cur.req_cycles++;
                if (wait_cnt >= gnt_delay) begin
                    obi_gnt = 1'b1;
                    if (cur.we) begin
                        obi_mem[cur.addr] = merge(obi_mem.exists(cur.addr) ? obi_mem[cur.addr]
                                                  : dflt(cur.addr), cur.wdata, cur.be);
                    end else begin
                        resp_data = obi_mem.exists(cur.addr) ? obi_mem[cur.addr] : dflt(cur.addr);
                    end
                    obi_q.push_back(cur);
                    pending = 1; rv_cnt = 0; rv_lim = rv_delay;
                    seen = 0; wait_cnt = 0;
                end else wait_cnt++;
            end else begin
                obi_rvalid = ($urandom_range(0, 3) == 0);  // must be ignored outside RESP
                wait_cnt = 0; seen = 0;
            end
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic [32:0] exp_q[$];   // {is_err, wb_dat_o}

    initial begin
        logic        prev_ack = 0, prev_err = 0;
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (wb_ack && wb_err) check("ack_and_err", 32'd1, 32'd0);
                if (wb_ack) check("ack_width", {31'd0, prev_ack}, 32'd0);
                if (wb_err) check("err_width", {31'd0, prev_err}, 32'd0);
                if (wb_ack || wb_err) begin
                    if (exp_q.size() == 0) begin
                        check("stray_resp", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_kind", {31'd0, wb_err}, {31'd0, e[32]});
                        check("wb_dat_o", wb_dat_r, e[31:0]);
                    end
                end
            end
            prev_ack = wb_ack;
            prev_err = wb_err;
        end
    end

    // ---------------- WB master driver ----------------
    // Called at a negedge; returns at the negedge where the response is seen.
    task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int gd, input int rd,
                          input bit b2b, input bit exp_err);
        int          lat = 0, req_lat = 0, exp_lat;
        logic [31:0] old;
        obi_t        o;
        gnt_delay = gd; rv_delay = rd;
        wb_cyc = 1; wb_stb = 1; wb_we = we; wb_adr = adr; wb_dat_w = dat; wb_sel = sel;
        old = ref_mem.exists(adr) ? ref_mem[adr] : dflt(adr);
        if (exp_err) begin
            exp_q.push_back({1'b1, last_rd});
        end else if (we) begin
            ref_mem[adr] = merge(old, dat, sel);
            exp_q.push_back({1'b0, last_rd});
        end else begin
            last_rd = old;
            exp_q.push_back({1'b0, old});
        end
        do begin
            @(negedge clk);
            lat++;
            if (obi_req && req_lat == 0) req_lat = lat;
        end while (!(wb_ack || wb_err) && lat < 200);
        exp_lat = exp_err ? TO + 1 : 3 + gd + rd + (b2b ? 1 : 0);
        check("ack_latency", lat, exp_lat);
        check("req_start", req_lat, b2b ? 2 : 1);
        if (exp_err) begin
            check("req_after_err", {31'd0, obi_req}, 32'd0);
        end else if (obi_q.size() == 0) begin
            check("obi_txn_seen", 32'd0, 32'd1);
        end else begin
            o = obi_q.pop_front();
            check("obi_addr", o.addr, adr);
            check("obi_we", {31'd0, o.we}, {31'd0, we});
            check("obi_be", {28'd0, o.be}, {28'd0, sel});
            if (we) check("obi_wdata", o.wdata, dat);
            check("req_cycles", o.req_cycles, gd + 1);
            check("req_stable", {31'd0, o.stable}, 32'd1);
        end
    endtask

    task automatic idle_bus(input int n);
        wb_cyc = 0; wb_stb = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ack"},   {31'd0, wb_ack}, 32'd0);
        check({tag, "_err"},   {31'd0, wb_err}, 32'd0);
        check({tag, "_dat"},   wb_dat_r, 32'd0);
        check({tag, "_req"},   {31'd0, obi_req}, 32'd0);
        check({tag, "_addr"},  obi_addr, 32'd0);
        check({tag, "_we"},    {31'd0, obi_we}, 32'd0);
        check({tag, "_be"},    {28'd0, obi_be}, 32'd0);
        check({tag, "_wdata"}, obi_wdata, 32'd0);
        check({tag, "_state"}, {29'd0, state_dbg}, {29'd0, ST_IDLE});
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int p0;
        bit b2b;
        obi_t o;
        rst_n = 0; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_adr = 0; wb_dat_w = 0; wb_sel = 0;
        last_rd = 0;
        ref_mem[32'h0040_0010] = 32'hDEAD_BEEF;
        obi_mem[32'h0040_0010] = 32'hDEAD_BEEF;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1;
        @(negedge clk);

        // single read, zero wait states
        do_txn(0, 32'h0040_0010, 32'h0, 4'hF, 0, 0, 0, 0);
        idle_bus(2);
        // write with two gnt wait cycles, then read it back
        do_txn(1, 32'h0040_0020, 32'h1234_5678, 4'b0011, 2, 0, 0, 0);
        idle_bus(1);
        do_txn(0, 32'h0040_0020, 32'h0, 4'hF, 0, 1, 0, 0);
        idle_bus(1);
        // back-to-back reads
        do_txn(0, 32'h0040_0010, 32'h0, 4'hF, 0, 0, 0, 0);
        do_txn(0, 32'h0040_0024, 32'h0, 4'hF, 0, 0, 1, 0);
        idle_bus(2);

        // abort while waiting for rvalid
        p0 = rvalid_pulses;
        gnt_delay = 0; rv_delay = 4;
        wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'h0040_0030; wb_sel = 4'hF;
        repeat (2) @(negedge clk);
        idle_bus(8);
        check("abort_rvalid", rvalid_pulses, p0 + 1);
        check("abort_obi_txn", obi_q.size(), 1);
        if (obi_q.size() > 0) begin
            o = obi_q.pop_front();
            check("abort_addr", o.addr, 32'h0040_0030);
        end
        check("abort_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
        do_txn(0, 32'h0040_0010, 32'h0, 4'hF, 1, 0, 0, 0);
        idle_bus(2);

        // asynchronous reset while in REQ
        gnt_delay = 50;
        wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'h0040_0034;
        wb_dat_w = 32'hCAFE_F00D; wb_sel = 4'hF;
        repeat (2) @(negedge clk);
        check("pre_reset_req", {31'd0, obi_req}, 32'd1);
        #2 rst_n = 0;
        #1 check_outputs_zero("async_reset");
        wb_cyc = 0; wb_stb = 0;
        last_rd = 0;
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        do_txn(0, 32'h0040_0010, 32'h0, 4'hF, 0, 0, 0, 0);
        idle_bus(2);

`ifdef WB_OBI_BRIDGE_TIMEOUT_EN
        // responder never grants
        do_txn(0, 32'h0040_0038, 32'h0, 4'hF, 1000, 0, 0, 1);
        idle_bus(2);
        check("timeout_state", {29'd0, state_dbg}, {29'd0, ST_IDLE});
        do_txn(0, 32'h0040_0010, 32'h0, 4'hF, 0, 0, 0, 0);
        idle_bus(1);
`endif

        // randomized traffic
        b2b = 0;
        for (int i = 0; i < 40; i++) begin
            do_txn(logic'($urandom_range(0, 1)), 32'h0040_0000 + 4 * $urandom_range(0, 7),
                   $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                   $urandom_range(0, 3), b2b, 0);
            b2b = ($urandom_range(0, 2) == 0);
            if (!b2b) idle_bus($urandom_range(1, 3));
        end
        idle_bus(4);
        check("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
